// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and the stage entry bundle for pipe_stage_reg.
package pipe_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RADDR_W_DEF = 3;
  localparam int CTRL_W_DEF  = 7;

  // Bit positions inside the ctrl bundle
  localparam int CTRL_BRANCH            = 0;
  localparam int CTRL_MEM_WRITE         = 1;
  localparam int CTRL_MEM_READ          = 2;
  localparam int CTRL_REG_WRITE         = 3;
  localparam int CTRL_REG_WRITE_ADDRESS = 4;
  localparam int CTRL_MDR               = 5;
  localparam int CTRL_RES               = 6;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0]  ctrl;
    logic [RADDR_W_DEF-1:0] rs;
    logic [RADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0]  ar;
    logic [DATA_W_DEF-1:0]  data;
  } stage_entry_t;

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus entry register; clear beats load.
// Single-cycle update, no flow control of its own.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter type entry_t = stage_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  entry_t d,
  output logic   valid,
  output entry_t q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      // payload is kept so the output fields hold their last value
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register, 1-cycle latency; PIPE_STAGE_SKID_EN adds a skid slot so in_ready is registered.
// Backpressure: without skid in_ready follows out_ready combinationally; flush squashes everything and blocks input.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [RADDR_W-1:0] in_rs,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_ar,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [RADDR_W-1:0] out_rs,
  output logic [RADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]  out_ar,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  ar;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t in_ent;
  entry_t head_d;
  entry_t head_q;
  logic   head_valid;
  logic   head_load;
  logic   head_clear;
  logic   run_q;
  logic   accept;
  logic   release_hd;

  always_comb begin
    in_ent      = '0;
    in_ent.ctrl = in_ctrl;
    in_ent.rs   = in_rs;
    in_ent.rd   = in_rd;
    in_ent.ar   = in_ar;
    in_ent.data = in_data;
  end

  // Holds in_ready low during reset and until the first edge after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign accept     = in_valid && in_ready;
  assign release_hd = head_valid && out_ready;

  pipe_slot #(.entry_t(entry_t)) u_head (
    .clock (clock),
    .reset (reset),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .valid (head_valid),
    .q     (head_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   skid_load;
  logic   skid_clear;

  // skid_valid is a flop, so out_ready never reaches in_ready
  assign in_ready = run_q && !skid_valid && !flush;

  always_comb begin
    head_d     = skid_valid ? skid_q : in_ent;
    head_load  = !flush && ((!head_valid && accept) ||
                            (release_hd && (skid_valid || accept)));
    head_clear = flush || (release_hd && !skid_valid && !accept);
    skid_load  = !flush && accept && head_valid && !release_hd;
    skid_clear = flush || (release_hd && skid_valid);
  end

  pipe_slot #(.entry_t(entry_t)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_ent),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign occupancy = count_valid(head_valid, skid_valid);
`else
  assign in_ready = run_q && (!head_valid || out_ready) && !flush;

  always_comb begin
    head_d     = in_ent;
    head_load  = accept;
    head_clear = flush || (release_hd && !accept);
  end

  assign occupancy = count_valid(head_valid, 1'b0);
`endif

  assign out_valid = head_valid;
  assign out_ctrl  = head_valid ? head_q.ctrl : '0;
  assign out_rs    = head_q.rs;
  assign out_rd    = head_q.rd;
  assign out_ar    = head_q.ar;
  assign out_data  = head_q.data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model, directed scenarios then random traffic.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [15:0] ar;
    logic [15:0] data;
  } ent_t;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_ctrl;
  logic [2:0]  in_rs;
  logic [2:0]  in_rd;
  logic [15:0] in_ar;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_ctrl;
  logic [2:0]  out_rs;
  logic [2:0]  out_rd;
  logic [15:0] out_ar;
  logic [15:0] out_data;
  logic [1:0]  occupancy;

  pipe_stage_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rs     (in_rs),
    .in_rd     (in_rd),
    .in_ar     (in_ar),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rs    (out_rs),
    .out_rd    (out_rd),
    .out_ar    (out_ar),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  ent_t last;
  bit   run;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[44:0];
  endfunction

  function automatic bit coin(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // One cycle, entered at posedge+1: drive, compare against the model, advance the model.
  task automatic step(input bit iv, input bit ordy, input bit fl, input ent_t e, output bit acc);
    bit         exp_rdy;
    bit         rel;
    logic [6:0] exp_ctrl;
    if (mq.size() != 0) last = mq[0];
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    {in_ctrl, in_rs, in_rd, in_ar, in_data} = e;
    #2;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = run && !fl && (mq.size() < 2);
`else
    exp_rdy = run && !fl && (mq.size() == 0 || ordy);
`endif
    exp_ctrl = (mq.size() != 0) ? mq[0].ctrl : 7'd0;
    check_val("in_ready",  32'(in_ready),  32'(exp_rdy));
    check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_val("occupancy", 32'(occupancy), 32'(mq.size()));
    check_val("out_ctrl",  32'(out_ctrl),  32'(exp_ctrl));
    check_val("out_rs",    32'(out_rs),    32'(last.rs));
    check_val("out_rd",    32'(out_rd),    32'(last.rd));
    check_val("out_ar",    32'(out_ar),    32'(last.ar));
    check_val("out_data",  32'(out_data),  32'(last.data));
    acc = iv && exp_rdy;
    rel = (mq.size() != 0) && ordy;
    @(posedge clock);
    #1;
    if (fl) mq.delete();
    else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    run = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_out_ctrl"},  32'(out_ctrl),  32'd0);
    check_val({tag, "_out_rs"},    32'(out_rs),    32'd0);
    check_val({tag, "_out_rd"},    32'(out_rd),    32'd0);
    check_val({tag, "_out_ar"},    32'(out_ar),    32'd0);
    check_val({tag, "_out_data"},  32'(out_data),  32'd0);
    check_val({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    ent_t e;
    ent_t abc[3];
    bit   acc;
    bit   pend;
    int   idx;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_ctrl, in_rs, in_rd, in_ar, in_data} = '0;
    run = 1'b0; last = '0;
    #2;
    check_all_zero("por");
    @(posedge clock); #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, rand_ent(), acc);   // in_ready still low here
    while (mq.size() != 0) step(1'b0, 1'b1, 1'b0, '0, acc);

    // Back-to-back streaming, data 0..7
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        check_val("stream_data", 32'(out_data), 32'(i - 1));
        check_val("stream_occ",  32'(occupancy), 32'd1);
      end
      e = rand_ent();
      e.data = 16'(i);
      step(1'b1, 1'b1, 1'b0, e, acc);
    end
    check_val("stream_last", 32'(out_data), 32'd7);
    step(1'b0, 1'b1, 1'b0, '0, acc);

    // Stall with A,B,C offered, then release
    for (int i = 0; i < 3; i++) abc[i] = rand_ent();
    idx = 0;
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0, abc[idx], acc);
      if (acc) idx++;
    end
    check_val("stall_occ", 32'(occupancy), 32'(CAP));
    for (int t = 0; t < 10 && idx < 3; t++) begin
      step(1'b1, 1'b1, 1'b0, abc[idx], acc);
      if (acc) idx++;
    end
    check_val("stall_all_in", 32'(idx), 32'd3);
    for (int t = 0; t < 6 && mq.size() != 0; t++) step(1'b0, 1'b1, 1'b0, '0, acc);

    // Flush while full with an incoming entry
    repeat (CAP) step(1'b1, 1'b0, 1'b0, rand_ent(), acc);
    step(1'b1, 1'b1, 1'b1, rand_ent(), acc);
    check_val("flush_vld",  32'(out_valid), 32'd0);
    check_val("flush_ctrl", 32'(out_ctrl),  32'd0);
    check_val("flush_occ",  32'(occupancy), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0, acc);

    // Asynchronous reset mid-stream while full
    repeat (CAP) step(1'b1, 1'b0, 1'b0, rand_ent(), acc);
    in_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    mq.delete(); last = '0; run = 1'b0;
    @(posedge clock); #4;
    reset = 1'b1;
    #1;
    check_val("rst_rel_rdy", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    run = 1'b1;
    e = rand_ent();
    e.ar = 16'h1234;
    step(1'b1, 1'b0, 1'b0, e, acc);
    check_val("rst_first_vld", 32'(out_valid), 32'd1);
    check_val("rst_first_ar",  32'(out_ar),    32'h1234);

    // Random traffic; a stalled offer is held until accepted
    pend = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit iv;
      if (!pend) e = rand_ent();
      iv = pend || coin(70);
      step(iv, coin(60), coin(4), e, acc);
      pend = iv && !acc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of address-result and register-data payloads.
REQ-002 Parameter RADDR_W, default 3, width of source/destination register-number fields.
REQ-003 Parameter CTRL_W, default 7, width of the control-bit bundle (branch, mem_write, mem_read, reg_write, reg_write_address, mdr, res).
REQ-004 Port clock, in, 1, single clock; all state updates on posedge.
REQ-005 Port reset, in, 1, asynchronous active-low reset.
REQ-006 Port flush, in, 1, synchronous squash of all held entries.
REQ-007 Port in_valid, in, 1, upstream stage presents a valid entry.
REQ-008 Port in_ready, out, 1, block accepts the entry this cycle.
REQ-009 Ports in_ctrl/in_rs/in_rd/in_ar/in_data, in, CTRL_W/RADDR_W/RADDR_W/DATA_W/DATA_W, upstream entry fields.
REQ-010 Port out_valid, out, 1, held entry is valid.
REQ-011 Port out_ready, in, 1, downstream consumes the head entry this cycle.
REQ-012 Ports out_ctrl/out_rs/out_rd/out_ar/out_data, out, same widths, head entry fields.
REQ-013 Port occupancy, out, 2, number of valid held entries (0..2).

Function
REQ-014 The block SHALL accept an entry when in_valid && in_ready, and SHALL release the head when out_valid && out_ready.
REQ-015 Latency SHALL be exactly one cycle: an entry accepted at edge N appears on the out_* ports after edge N when the head slot is empty or is released at edge N.
REQ-016 out_ctrl SHALL read all-zero whenever out_valid is 0 (bubble); other out_* fields hold their last value.
REQ-017 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-018 If accept and release happen in the same cycle, occupancy SHALL remain unchanged and throughput SHALL be one entry per cycle.
REQ-019 On flush=1, all entries SHALL become invalid at the next edge, occupancy becomes 0, and in_ready SHALL be 0 that cycle (no entry accepted).
REQ-020 flush SHALL take priority over simultaneous accept and release.
REQ-021 in_valid without in_ready SHALL leave state unchanged; upstream holds its fields.

Reset
REQ-022 While reset=0, every output SHALL be zero (out_valid=0, out_ctrl=0, out_rs=0, out_rd=0, out_ar=0, out_data=0, occupancy=0, in_ready=0), asynchronously.
REQ-023 in_ready SHALL rise on the first posedge after reset deasserts; reset mid-transfer SHALL discard all entries.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN defined: two slots (head + skid); in_ready SHALL be the registered value !skid_valid && !flush, with no combinational path from out_ready; a stalled head with an incoming accept SHALL park that entry in skid, and skid SHALL move to head on release.
REQ-025 PIPE_STAGE_SKID_EN undefined: one slot; in_ready SHALL be (!out_valid || out_ready) && !flush, combinationally; occupancy SHALL never exceed 1.

Structure
REQ-026 Shared package pipe_pkg SHALL hold the default widths, ctrl bit-index constants, and a typedef stage_entry_t bundling ctrl/rs/rd/ar/data.
REQ-027 One sub-module pipe_slot (a valid bit plus a stage_entry_t register with load, clear, and async reset) SHALL be instantiated once or twice.

Verification
REQ-028 Reset low mid-stream with occupancy=2 -> all outputs 0 immediately; after release, first accept of ar=16'h1234 appears with out_valid=1 next cycle.
REQ-029 out_ready=1, in_valid=1 for 8 cycles with data 0..7 -> out_data 0..7 on consecutive cycles, occupancy steady at 1.
REQ-030 (SKID_EN) out_ready=0 for 3 cycles while in_valid=1 with A,B,C -> A in head, B in skid, in_ready=0 from cycle 2, C held; out_ready=1 -> A,B,C emitted in order.
REQ-031 flush=1 with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=7'b0, occupancy=0, incoming entry not accepted.
REQ-032 Random in_valid/out_ready/flush for 10k cycles -> scoreboard shows in-order delivery, no loss except flushed entries, and occupancy equals scoreboard depth.
